// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter with a one-entry holding register in front of the
// shifter, so the next byte can be accepted while the current frame is on the
// line. Frames go out back-to-back with no idle gap.
//
// Parameters
//   SIZE          data bits per frame (fixed at 8)
//   FREQ_DIV_FACT clock cycles per bit period (>= 2)
//
// Ports
//   CLK       system clock, rising edge
//   RST_N     synchronous active-low reset
//   TX_VALID  byte on DIN is offered
//   DIN       byte to transmit, sampled only on a handshake
//   TX_READY  holding register empty, a byte can be accepted
//   TXD       serial line, idles high (registered)
//   TX_BUSY   a frame is in progress (registered)
//   TX_DONE   one-cycle pulse after each stop bit completes (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int SIZE          = 8,
  parameter int FREQ_DIV_FACT = 10
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            TX_VALID,
  input  logic [SIZE-1:0] DIN,
  output logic            TX_READY,
  output logic            TXD,
  output logic            TX_BUSY,
  output logic            TX_DONE
);

  localparam int                BAUD_W    = (FREQ_DIV_FACT > 2) ? $clog2(FREQ_DIV_FACT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(FREQ_DIV_FACT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        BIT_LAST  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_r;
  logic [SIZE-1:0]   shift_r;
  logic [SIZE-1:0]   hold_r;
  logic              hold_full_r;
  logic              txd_r;
  logic              busy_r;
  logic              done_r;

  logic              handshake_s;
  logic              bit_end_s;
  logic              load_hold_s;

  // Ready depends only on the registered holding flag, never on TX_VALID.
  assign handshake_s = TX_VALID & ~hold_full_r;
  assign bit_end_s   = (baud_r == BAUD_LAST);

  assign TX_READY = ~hold_full_r;
  assign TXD      = txd_r;
  assign TX_BUSY  = busy_r;
  assign TX_DONE  = done_r;

  // Decide whether an accepted byte goes to the holding register. In IDLE, and
  // at the final STOP edge, it bypasses the holding register into the shifter.
  always_comb begin
    load_hold_s = 1'b0;
    if (handshake_s && (state_r != ST_IDLE) && !((state_r == ST_STOP) && bit_end_s)) begin
      load_hold_s = 1'b1;
    end else begin
      load_hold_s = 1'b0;
    end
  end

  // Transmit FSM with counters, shifter, holding register and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      baud_r      <= '0;
      bit_r       <= 3'd0;
      shift_r     <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      txd_r       <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          baud_r <= '0;
          bit_r  <= 3'd0;
          if (handshake_s) begin
            shift_r <= DIN;
            state_r <= ST_START;
            txd_r   <= 1'b0;
            busy_r  <= 1'b1;
          end else if (hold_full_r) begin
            shift_r     <= hold_r;
            hold_full_r <= 1'b0;
            state_r     <= ST_START;
            txd_r       <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end_s) begin
            baud_r  <= '0;
            state_r <= ST_DATA;
            txd_r   <= shift_r[0];
          end else begin
            baud_r <= baud_r + BAUD_ONE;
            txd_r  <= 1'b0;
          end
        end

        ST_DATA: begin
          if (bit_end_s) begin
            baud_r <= '0;
            if (bit_r == BIT_LAST) begin
              bit_r   <= 3'd0;
              state_r <= ST_STOP;
              txd_r   <= 1'b1;
            end else begin
              bit_r   <= bit_r + 3'd1;
              // Next bit is presented from the pre-shift value to keep TXD registered.
              shift_r <= {1'b0, shift_r[SIZE-1:1]};
              txd_r   <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end

        ST_STOP: begin
          if (bit_end_s) begin
            baud_r <= '0;
            done_r <= 1'b1;
            if (hold_full_r) begin
              shift_r     <= hold_r;
              hold_full_r <= 1'b0;
              state_r     <= ST_START;
              txd_r       <= 1'b0;
            end else if (handshake_s) begin
              shift_r <= DIN;
              state_r <= ST_START;
              txd_r   <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              txd_r   <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
            txd_r  <= 1'b1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          baud_r  <= '0;
          bit_r   <= 3'd0;
          txd_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase

      // Capture into the holding register; never coincides with a hold-to-shifter move.
      if (load_hold_s) begin
        hold_r      <= DIN;
        hold_full_r <= 1'b1;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx. Two instances (divider 10 and divider 2) share a clock.
// A frame-level reference model predicts the line level from the frame start
// time and byte, plus ready/busy/done, and every output is compared each cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, vld0, rdy0, txd0, busy0, done0;
  logic [7:0] din0;
  logic       rst1, vld1, rdy1, txd1, busy1, done1;
  logic [7:0] din1;

  uart_tx #(.SIZE(8), .FREQ_DIV_FACT(10)) u_dut0 (
    .CLK(clk), .RST_N(rst0), .TX_VALID(vld0), .DIN(din0),
    .TX_READY(rdy0), .TXD(txd0), .TX_BUSY(busy0), .TX_DONE(done0)
  );

  uart_tx #(.SIZE(8), .FREQ_DIV_FACT(2)) u_dut1 (
    .CLK(clk), .RST_N(rst1), .TX_VALID(vld1), .DIN(din1),
    .TX_READY(rdy1), .TXD(txd1), .TX_BUSY(busy1), .TX_DONE(done1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt [2];

  // Reference model: a frame is (start cycle, byte); one optional pending byte.
  int         f_div   [2] = '{10, 2};
  logic       m_act   [2];
  logic       m_pend  [2];
  logic       m_done  [2];
  logic       m_acc   [2];
  int         m_start [2];
  logic [7:0] m_byte  [2];
  logic [7:0] m_pbyte [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_edge(input int i, input logic v, input logic [7:0] d, input logic rn);
    logic hs;
    m_done[i] = 1'b0;
    if (!rn) begin
      m_act[i]  = 1'b0;
      m_pend[i] = 1'b0;
    end else begin
      hs = v && !m_pend[i];
      if (hs) m_acc[i] = 1'b1;
      if (m_act[i] && (cyc - m_start[i] == 10 * f_div[i])) begin
        m_done[i] = 1'b1;
        if (m_pend[i]) begin
          m_start[i] = cyc; m_byte[i] = m_pbyte[i]; m_pend[i] = 1'b0;
        end else if (hs) begin
          m_start[i] = cyc; m_byte[i] = d;
        end else begin
          m_act[i] = 1'b0;
        end
      end else if (hs) begin
        if (m_act[i]) begin
          m_pend[i] = 1'b1; m_pbyte[i] = d;
        end else begin
          m_act[i] = 1'b1; m_start[i] = cyc; m_byte[i] = d;
        end
      end
    end
  endtask

  // Line level: bit period 0 is start, 1..8 are data LSB first, 9 is stop.
  function automatic logic exp_txd(input int i);
    int idx;
    if (!m_act[i]) return 1'b1;
    idx = (cyc - m_start[i]) / f_div[i];
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[i][idx-1];
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      if (!vld0) din0 = 8'($urandom);
      if (!vld1) din1 = 8'($urandom);
      @(posedge clk);
      cyc++;
      model_edge(0, vld0, din0, rst0);
      model_edge(1, vld1, din1, rst1);
      #1;
      if (done0 === 1'b1) done_cnt[0]++;
      if (done1 === 1'b1) done_cnt[1]++;
      check_eq("txd0",   32'(txd0),  32'(exp_txd(0)));
      check_eq("busy0",  32'(busy0), 32'(m_act[0]));
      check_eq("ready0", 32'(rdy0),  32'(!m_pend[0]));
      check_eq("done0",  32'(done0), 32'(m_done[0]));
      check_eq("txd1",   32'(txd1),  32'(exp_txd(1)));
      check_eq("busy1",  32'(busy1), 32'(m_act[1]));
      check_eq("ready1", 32'(rdy1),  32'(!m_pend[1]));
      check_eq("done1",  32'(done1), 32'(m_done[1]));
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_pend[i] = 1'b0; m_done[i] = 1'b0; m_acc[i] = 1'b0;
      m_start[i] = 0; m_byte[i] = 8'h00; m_pbyte[i] = 8'h00; done_cnt[i] = 0;
    end
    rst0 = 1'b0; vld0 = 1'b0; din0 = 8'h00;
    rst1 = 1'b0; vld1 = 1'b0; din1 = 8'h00;

    // Reset state
    tick(2);
    rst0 = 1'b1; rst1 = 1'b1;
    tick(3);

    // Single byte 0xA5, DIN wiggles afterwards
    base = done_cnt[0];
    vld0 = 1'b1; din0 = 8'hA5; tick(1);
    vld0 = 1'b0; tick(110);
    check_eq("single_done_cnt", 32'(done_cnt[0] - base), 32'd1);

    // Back-to-back 0x00 then 0xFF
    base = done_cnt[0];
    vld0 = 1'b1; din0 = 8'h00; tick(1);
    din0 = 8'hFF; tick(1);
    vld0 = 1'b0; tick(205);
    check_eq("b2b_done_cnt", 32'(done_cnt[0] - base), 32'd2);

    // Stalled source: third byte held valid until accepted
    base = done_cnt[0];
    vld0 = 1'b1; din0 = 8'($urandom); tick(1);
    din0 = 8'($urandom); tick(1);
    din0 = 8'($urandom); m_acc[0] = 1'b0;
    for (int k = 0; k < 400 && !m_acc[0]; k++) tick(1);
    vld0 = 1'b0;
    tick(320);
    check_eq("stall_done_cnt", 32'(done_cnt[0] - base), 32'd3);

    // Reset mid-frame with a byte held
    vld0 = 1'b1; din0 = 8'($urandom); tick(1);
    din0 = 8'($urandom); tick(1);
    vld0 = 1'b0; tick(43);
    base = done_cnt[0];
    rst0 = 1'b0; tick(1);
    rst0 = 1'b1; tick(150);
    check_eq("rst_done_cnt", 32'(done_cnt[0] - base), 32'd0);

    // Handshake exactly at the last STOP edge with holding register empty
    base = done_cnt[0];
    vld0 = 1'b1; din0 = 8'($urandom); tick(1);
    vld0 = 1'b0; tick(99);
    vld0 = 1'b1; din0 = 8'h3C; tick(1);
    vld0 = 1'b0; tick(110);
    check_eq("stop_hs_done_cnt", 32'(done_cnt[0] - base), 32'd2);

    // Minimum divider, byte 0x81
    base = done_cnt[1];
    vld1 = 1'b1; din1 = 8'h81; tick(1);
    vld1 = 1'b0; tick(25);
    check_eq("min_div_done_cnt", 32'(done_cnt[1] - base), 32'd1);

    // Randomized traffic on both instances
    for (int k = 0; k < 800; k++) begin
      vld0 = ($urandom_range(0, 7) == 0);
      din0 = 8'($urandom);
      vld1 = ($urandom_range(0, 3) == 0);
      din1 = 8'($urandom);
      tick(1);
    end
    vld0 = 1'b0; vld1 = 1'b0;
    tick(220);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises 8-bit bytes into 8N1 frames on `TXD`. It is the transmit counterpart of the existing receiver, so its line format and `FREQ_DIV_FACT` clock divider match the receive path. A one-entry holding register sits in front of the shifter, so a new byte can be accepted while the current frame is still being sent. Frames go out back-to-back with no idle gap on the line.

## Interface
- `SIZE`, default 8: data bits per frame. Fixed at 8; other values are not supported.
- `FREQ_DIV_FACT`, default 10: clock cycles per bit period. Legal range is 2 or greater.
- `CLK`, input, 1: system clock. All logic is on its rising edge.
- `RST_N`, input, 1: one clock; reset is synchronous and active-low.
- `TX_VALID`, input, 1: the byte on `DIN` is offered for transmission.
- `DIN`, input, 8: byte to transmit. Sampled only on a handshake.
- `TX_READY`, output, 1: the holding register is empty and a byte can be accepted.
- `TXD`, output, 1: serial line. Idles high.
- `TX_BUSY`, output, 1: a frame is in progress (FSM is not in IDLE).
- `TX_DONE`, output, 1: one-cycle pulse after each stop bit completes.

## Operation
- **Frame format:** one start bit (0), 8 data bits sent LSB first, one stop bit (1). A frame is 10 × `FREQ_DIV_FACT` cycles long.
- **Handshake:** a byte is accepted at any rising edge where `TX_VALID` and `TX_READY` are both 1.
  - If the FSM is in IDLE, the byte loads directly into the shifter and the FSM goes to START at that edge. The holding register stays empty.
  - Otherwise the byte is stored in the holding register, which is now full, and `TX_READY` is 0.
- **State machine:**
  - IDLE → START on a handshake, or when the holding register is full.
  - START → DATA after one bit period.
  - DATA shifts out 8 bits. A bit counter runs 0..7 and advances at the end of each bit period. DATA → STOP after bit 7's period ends.
  - STOP → START if the holding register is full: the held byte moves to the shifter and the holding register empties.
  - STOP → START if there is a handshake on the same edge with the holding register empty: `DIN` goes straight to the shifter.
  - STOP → IDLE otherwise.
- **Baud counter:** counts 0..`FREQ_DIV_FACT`-1. It clears on every state entry, and the bit period ends at the edge where it equals `FREQ_DIV_FACT`-1.
- **`TXD`** is a registered output: 0 in START, the current shifter LSB in DATA, 1 in STOP and IDLE.
- **`TX_DONE`** goes high for exactly one cycle after the edge that ends STOP. This applies whether the next state is START or IDLE.
- **`TX_READY`** is the inverse of the registered holding-full flag. There is no combinational path from `TX_VALID` to `TX_READY`.
- **Handshake at the last STOP edge with the holding register full:** impossible, because `TX_READY` is 0 then. When the held byte moves to the shifter, `TX_READY` returns to 1 in the following cycle.
- **`DIN` changes** while no handshake is happening have no effect on the frame in progress.

## Timing
- **Reset values** (after the first edge with `RST_N`=0): `TXD`=1, `TX_BUSY`=0, `TX_DONE`=0, `TX_READY`=1. The FSM is in IDLE, the holding register is empty, and both counters are 0.
- **Reset mid-frame:** the frame is aborted, `TXD` returns to 1 at the reset edge, and any held byte is discarded. No `TX_DONE` pulse is produced.
- **Latency:** handshake at edge N with the FSM in IDLE gives `TXD`=0 and `TX_BUSY`=1 starting from edge N.
- **Bit boundaries:** data bit k starts at edge N + (k+1) × `FREQ_DIV_FACT`. The stop bit starts at N + 9 × `FREQ_DIV_FACT`.
- **Frame end:** STOP ends at edge N + 10 × `FREQ_DIV_FACT`.
  - With a byte pending, `TXD` falls to the next start bit at that edge.
  - With nothing pending, `TX_BUSY` falls at that edge.
  - In both cases `TX_DONE` is high for the cycle after that edge.
- **Throughput:** sustained rate is one byte every 10 × `FREQ_DIV_FACT` cycles.

## Test plan
- **Single byte:** `FREQ_DIV_FACT`=10, reset, then one handshake with `DIN`=0xA5 → `TXD` shows 0,1,0,1,0,0,1,0,1,1. Each level lasts 10 cycles and the whole frame is 100 cycles. `TX_DONE` pulses once, then the line idles high and `TX_BUSY`=0.
- **Back-to-back:** send 0x00 and immediately offer 0xFF.
  - 0xFF is accepted 1 cycle later and `TX_READY` stays 0 until cycle 100.
  - The second frame's start bit begins at cycle 100 with no high gap.
  - `TXD` then shows 0, eight 1s, and 1 (stop).
- **Stalled source:** hold `TX_VALID`=1 with a third byte while the holding register is full → no acceptance until `TX_READY` rises. Exactly 3 frames are sent and the bytes arrive in order.
- **Reset mid-frame:** assert `RST_N`=0 at cycle 45 of a frame with a byte held → `TXD`=1, `TX_BUSY`=0, `TX_READY`=1 after that edge. No `TX_DONE` pulse, and the held byte is never transmitted.
- **Handshake at STOP's last edge with the holding register empty:** new byte 0x3C → the start bit follows the previous stop bit directly. `TX_DONE` pulses once, and the 0x3C frame is correct (0,0,0,1,1,1,1,0,0,1).
- **Minimum divider:** `FREQ_DIV_FACT`=2, byte 0x81 → the frame is 20 cycles long and each bit is exactly 2 cycles.
